imem_loadable: RTL and testbench
================================

IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 Parameter ADDR_W, default 6, word-address width; depth DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ren  input  1  read request.
REQ-006 raddr  input  ADDR_W  word-aligned read address.
REQ-007 rdata  output  DATA_W  read data, registered.
REQ-008 rvalid  output  1  rdata holds the result of an accepted read.
REQ-009 busy  output  1  block is in CLEAR or LOAD; reads are not accepted.
REQ-010 ld_start  input  1  begin a program load at word 0.
REQ-011 ld_valid  input  1  ld_data carries a word to write.
REQ-012 ld_data  input  DATA_W  load word.
REQ-013 ld_last  input  1  qualifies the final word of a load, valid only with ld_valid.
REQ-014 ld_ovf  output  1  sticky flag: the load pointer wrapped past DEPTH-1.

Function
REQ-015 The FSM SHALL have states CLEAR, IDLE and LOAD; busy = (state != IDLE).
REQ-016 In CLEAR, the block SHALL write zero to address clr_ptr each cycle, increment clr_ptr, and enter IDLE in the cycle after writing DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
REQ-017 In IDLE with ld_start=1, the block SHALL enter LOAD next cycle with ld_ptr=0 and ld_ovf=0.
REQ-018 In LOAD, each cycle with ld_valid=1 SHALL write ld_data to ld_ptr and increment ld_ptr modulo DEPTH; cycles with ld_valid=0 SHALL leave memory and ld_ptr unchanged.
REQ-019 A LOAD write at ld_ptr=DEPTH-1 SHALL wrap ld_ptr to 0 and set ld_ld_ovf=1 until the next ld_start or reset.
REQ-020 ld_valid=1 with ld_last=1 in LOAD SHALL write the word and return to IDLE next cycle.
REQ-021 ld_valid, ld_last and ld_start SHALL be ignored outside the states named above; ld_start in LOAD does not restart the load.
REQ-022 In IDLE with ren=1 and ld_start=0, the block SHALL present RAM[raddr] on rdata with rvalid=1 in the next cycle (1-cycle latency).
REQ-023 A read with ren=0, or outside IDLE, SHALL drive rvalid=0 next cycle; rdata SHALL hold its last value.
REQ-024 When ren=1 and ld_start=1 in IDLE in the same cycle, the load SHALL win; the read is dropped and rvalid=0 next cycle.
REQ-025 A read issued in the cycle before a LOAD write to the same address SHALL return the old contents (read-before-write ordering).
REQ-026 Back-to-back reads SHALL sustain one result per cycle.

Reset
REQ-027 reset=1 SHALL force rvalid=0, rdata=0, ld_ovf=0, ld_ptr=0 and clr_ptr=0 next cycle, taking priority over all other inputs.
REQ-028 reset asserted mid-LOAD or mid-CLEAR SHALL abort the operation; words already written stay written unless cleared by REQ-029.
REQ-029 The post-reset state SHALL be CLEAR when IMEM_CLEAR_EN is defined, and IDLE otherwise.

Configuration
REQ-030 Macro IMEM_CLEAR_EN defined: CLEAR state and clr_ptr exist; every reset zeroes all DEPTH words, and busy=1 for DEPTH cycles after reset deasserts.
REQ-031 IMEM_CLEAR_EN undefined: the CLEAR state and clr_ptr logic are removed, memory contents persist across reset, and busy=0 on the first cycle after reset.

Verification
REQ-032 CLEAR sweep (IMEM_CLEAR_EN, ADDR_W=6): release reset -> busy=1 for exactly 64 cycles; then reading addresses 0..63 gives rdata=0 and rvalid=1 each cycle after ren.
REQ-033 Load and read: load words 0x20080005, 0x2009000C, 0xAC090044 with ld_last on the third word -> busy drops; reading 0,1,2 returns the same words, one per cycle.
REQ-034 Wrap: load 65 words with ADDR_W=6 -> ld_ovf=1 and word 0 holds the 65th value; the next ld_start clears ld_ovf.
REQ-035 Contention: ren=1 with raddr=3 and ld_start=1 in the same cycle -> rvalid=0 next cycle and state=LOAD; reads issued during LOAD give rvalid=0.
REQ-036 Reset mid-load: assert reset after 10 of 20 words -> with IMEM_CLEAR_EN, all words read 0 after the sweep; without it, words 0..9 retain their loaded values and busy=0 one cycle after reset.

Source files
------------

// File: rtl/imem_loadable.sv
// Loadable instruction memory: 1-cycle registered read port plus a streaming program-load port.
// Define IMEM_CLEAR_EN to zero every word after each reset (busy during the sweep).
module imem_loadable #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ovf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

`ifdef IMEM_CLEAR_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CLEAR = 2'd2
  } state_e;
  localparam state_e RST_STATE = S_CLEAR;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1
  } state_e;
  localparam state_e RST_STATE = S_IDLE;
`endif

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic              ld_ovf_q, ld_ovf_d;
`ifdef IMEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
`endif

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ld_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (ld_valid && ld_last) state_d = S_IDLE;
      end
`ifdef IMEM_CLEAR_EN
      S_CLEAR: begin
        if (clr_ptr_q == PTR_MAX) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ld_ptr_q;
    mem_wdata = ld_data;
    rd_en     = 1'b0;
    ld_ptr_d  = ld_ptr_q;
    ld_ovf_d  = ld_ovf_q;
`ifdef IMEM_CLEAR_EN
    clr_ptr_d = clr_ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // a load request wins over a same-cycle read
        rd_en = ren && !ld_start;
        if (ld_start) begin
          ld_ptr_d = '0;
          ld_ovf_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          mem_we   = 1'b1;
          ld_ptr_d = ld_ptr_q + 1'b1;
          if (ld_ptr_q == PTR_MAX) ld_ovf_d = 1'b1;
        end
      end
`ifdef IMEM_CLEAR_EN
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
`endif
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ld_ptr_q <= '0;
      ld_ovf_q <= 1'b0;
`ifdef IMEM_CLEAR_EN
      clr_ptr_q <= '0;
`endif
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= mem_q[raddr];
      ld_ptr_q <= ld_ptr_d;
      ld_ovf_q <= ld_ovf_d;
`ifdef IMEM_CLEAR_EN
      clr_ptr_q <= clr_ptr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = (state_q != S_IDLE);
  assign ld_ovf = ld_ovf_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: a cycle model predicts outputs at each rising edge,
// a negedge monitor pops and compares. Works with or without IMEM_CLEAR_EN.
module tb_imem_loadable;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
`ifdef IMEM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ren = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          busy;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ovf;

  always #5 clk = ~clk;

  imem_loadable #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .ren(ren), .raddr(raddr),
    .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ovf(ld_ovf)
  );

  typedef struct {
    bit        rvalid;
    bit [31:0] rdata;
    bit        rd_known;
    bit        busy;
    bit        ovf;
  } exp_t;

  exp_t sbq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // reference model: mode 0 = sweeping, 1 = idle, 2 = loading
  int        m_mode = 1;
  int        m_clr_left = 0;
  bit [31:0] m_mem [DEPTH];
  bit        m_known [DEPTH];
  int        m_ptr = 0;
  bit        m_ovf = 0;
  bit        m_rv = 0;
  bit [31:0] m_rd = 0;
  bit        m_rdk = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_rv = 0; m_rd = 0; m_rdk = 1; m_ovf = 0; m_ptr = 0;
        m_mode = CLR_EN ? 0 : 1;
        m_clr_left = DEPTH;
      end else if (m_mode == 0) begin
        m_mem[DEPTH - m_clr_left] = 0;
        m_known[DEPTH - m_clr_left] = 1;
        m_clr_left--;
        if (m_clr_left == 0) m_mode = 1;
        m_rv = 0;
      end else if (m_mode == 1) begin
        if (ld_start) begin
          m_mode = 2; m_ptr = 0; m_ovf = 0; m_rv = 0;
        end else if (ren) begin
          m_rv = 1;
          m_rd = m_mem[int'(raddr)];
          m_rdk = m_known[int'(raddr)];
        end else begin
          m_rv = 0;
        end
      end else begin
        m_rv = 0;
        if (ld_valid) begin
          m_mem[m_ptr] = ld_data;
          m_known[m_ptr] = 1;
          if (m_ptr == DEPTH - 1) m_ovf = 1;
          m_ptr = (m_ptr + 1) % DEPTH;
          if (ld_last) m_mode = 1;
        end
      end
      e.rvalid = m_rv; e.rdata = m_rd; e.rd_known = m_rdk;
      e.busy = (m_mode != 1); e.ovf = m_ovf;
      sbq.push_back(e);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rvalid", {31'b0, rvalid}, {31'b0, e.rvalid});
        chk("busy", {31'b0, busy}, {31'b0, e.busy});
        chk("ld_ovf", {31'b0, ld_ovf}, {31'b0, e.ovf});
        if (e.rd_known) chk("rdata", rdata, e.rdata);
      end
    end
  end

  task automatic drv(bit r, bit re, int ra, bit st, bit v, logic [31:0] d, bit last);
    @(negedge clk);
    reset = r; ren = re; raddr = AW'(ra);
    ld_start = st; ld_valid = v; ld_data = d; ld_last = last;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(int a);
    drv(0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic ldw(logic [31:0] d, bit last);
    drv(0, 0, 0, 0, 1, d, last);
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    idle(DEPTH + 2);
    for (int a = 0; a < DEPTH; a++) rd(a);

    // short program load, then back-to-back reads
    drv(0, 0, 0, 1, 0, 0, 0);
    ldw(32'h2008_0005, 0);
    ldw(32'h2009_000C, 0);
    ldw(32'hAC09_0044, 1);
    rd(0); rd(1); rd(2);
    idle(1);

    // 65-word load wraps the pointer
    drv(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 65; i++) ldw(32'h1000_0000 + i, i == 64);
    rd(0); rd(1); rd(63);
    drv(0, 0, 0, 1, 0, 0, 0);
    ldw(32'hDEAD_BEEF, 1);
    rd(0);

    // read/load contention, then reads while loading
    drv(0, 1, 3, 1, 0, 0, 0);
    rd(3); rd(4);
    ldw(32'h0000_00A1, 0);
    drv(0, 1, 0, 0, 1, 32'h0000_00A2, 1);
    rd(0); rd(1);

    // reset in the middle of a 20-word load
    drv(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) ldw(32'h5000_0000 + i, 0);
    drv(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    idle(DEPTH + 2);
    for (int a = 0; a < 20; a++) rd(a);

    for (int c = 0; c < 4000; c++) begin
      drv($urandom_range(0, 299) == 0,
          $urandom_range(0, 1) == 1,
          int'($urandom_range(0, DEPTH - 1)),
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 9) < 7,
          $urandom,
          $urandom_range(0, 39) == 0);
    end
    idle(4);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
